// File: rtl/sub_chunked_if.sv
// sub_chunked_if -- bus bundle for the chunk-serial subtractor.
//
// Purpose: groups the operation handshake and chunk data of sub_chunked.
// Parameter W is the chunk width and must equal N/CC of the attached block.
//
// Handshake: start is a request with no ready; it is taken as chunk 0
// whenever the block is idle (busy=0). This includes the cycle in which
// done=1. While busy=1 the block samples a/b every cycle and ignores start.
// c_valid marks a fresh result chunk on c. c holds its value otherwise.
//
// Signals:
//   start      master->slave  begin an operation (this cycle carries chunk 0)
//   a, b       master->slave  minuend / subtrahend chunk, LS chunk first
//   c          slave->master  registered difference chunk
//   c_valid    slave->master  c carries a new chunk this cycle
//   busy       slave->master  block is sampling chunks 1..CC-1
//   done       slave->master  one-cycle pulse with the final chunk on c
//   borrow_out slave->master  final borrow (A < B); only with SUB_BORROW_OUT_EN
//   state_dbg  slave->master  FSM state for debug (0 = IDLE, 1 = BUSY)
interface sub_chunked_if #(
  parameter int W = 4
) ();
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         c_valid;
  logic         busy;
  logic         done;
`ifdef SUB_BORROW_OUT_EN
  logic         borrow_out;
`endif
  logic         state_dbg;

  modport master (
    output start, a, b,
`ifdef SUB_BORROW_OUT_EN
    input  borrow_out,
`endif
    input  c, c_valid, busy, done, state_dbg
  );

  modport slave (
    input  start, a, b,
`ifdef SUB_BORROW_OUT_EN
    output borrow_out,
`endif
    output c, c_valid, busy, done, state_dbg
  );
endinterface

// File: rtl/sub_chunked.sv
// sub_chunked -- N-bit subtractor that works on W = N/CC bit chunks, one
// chunk per clock, least significant chunk first. A borrow bit is carried
// between chunks. Each result chunk appears on c one cycle after its
// operands are sampled.
//
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous, active-high reset
//   bus  sub_chunked_if.slave (start, a, b, c, c_valid, busy, done,
//        state_dbg, and borrow_out when enabled)
//
// Parameters: N (total width, default 128), CC (cycles per operation,
// default 32). N must be a multiple of CC.
//
// Build option: define SUB_BORROW_OUT_EN to add the registered borrow_out
// output. It is loaded with the borrow of the final chunk, so it is 1
// exactly when A < B.
module sub_chunked #(
  parameter int N  = 128,
  parameter int CC = 32
) (
  input  logic        clk,
  input  logic        rst,
  sub_chunked_if.slave bus
);
  localparam int W  = N / CC;
  localparam int CW = (CC > 1) ? $clog2(CC) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          borrow_q, borrow_d;
  logic [W-1:0]  c_q, c_d;
  logic          c_valid_q, c_valid_d;
  logic          done_q, done_d;
`ifdef SUB_BORROW_OUT_EN
  logic          bo_q, bo_d;
`endif

  logic          borrow_in;
  logic [W:0]    diff_ext;

  // One extra bit on top captures the borrow. The top bit is 1 exactly
  // when a < b + borrow_in.
  assign diff_ext = {1'b0, bus.a} - {1'b0, bus.b} - {{W{1'b0}}, borrow_in};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    borrow_d  = borrow_q;
    c_d       = c_q;
    c_valid_d = 1'b0;
    done_d    = 1'b0;
    borrow_in = 1'b0;
`ifdef SUB_BORROW_OUT_EN
    bo_d      = bo_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Chunk 0 always starts with a clear borrow. Any borrow left from
          // an earlier or aborted operation is discarded.
          borrow_in = 1'b0;
          c_d       = diff_ext[W-1:0];
          c_valid_d = 1'b1;
          borrow_d  = diff_ext[W];
          if (CC == 1) begin
            done_d = 1'b1;
`ifdef SUB_BORROW_OUT_EN
            bo_d   = diff_ext[W];
`endif
          end else begin
            cnt_d   = CW'(1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // start is ignored here. Operands are taken every cycle.
        borrow_in = borrow_q;
        c_d       = diff_ext[W-1:0];
        c_valid_d = 1'b1;
        borrow_d  = diff_ext[W];
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(CC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
`ifdef SUB_BORROW_OUT_EN
          bo_d    = diff_ext[W];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      borrow_q  <= 1'b0;
      c_q       <= '0;
      c_valid_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef SUB_BORROW_OUT_EN
      bo_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      borrow_q  <= borrow_d;
      c_q       <= c_d;
      c_valid_q <= c_valid_d;
      done_q    <= done_d;
`ifdef SUB_BORROW_OUT_EN
      bo_q      <= bo_d;
`endif
    end
  end

  // BUSY spans exactly the cycles in which chunks 1..CC-1 are sampled.
  assign bus.c         = c_q;
  assign bus.c_valid   = c_valid_q;
  assign bus.busy      = (state_q == BUSY);
  assign bus.done      = done_q;
  assign bus.state_dbg = (state_q == BUSY);
`ifdef SUB_BORROW_OUT_EN
  assign bus.borrow_out = bo_q;
`endif
endmodule

// File: tb/tb_sub_chunked.sv
// tb_sub_chunked -- self-checking bench for sub_chunked (N=128, CC=32).
// The reference model works on whole N-bit operands. When an operation is
// accepted, it computes (A - B) mod 2^N and A < B. It then queues the CC
// result chunks. Each later clock shows one chunk from the queue. Fixed
// scenarios with hand-derived results pin the model. Random operations
// follow, with random gaps, start held or toggled during busy, and aborts
// by reset.
module tb_sub_chunked;
  localparam int N  = 128;
  localparam int CC = 32;
  localparam int W  = N / CC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sub_chunked_if #(.W(W)) bus ();

  sub_chunked #(.N(N), .CC(CC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  logic [N-1:0] cur_a, cur_b;
  logic         op_bo;
  logic [W-1:0] e_c;
  logic         e_valid, e_busy, e_done, e_bo;
  bit           chk_en = 1'b0;
  int           step_cyc, op_t0;

  task automatic model_step(input logic r, input logic s);
    logic [N-1:0] d;
    if (r) begin
      exp_q.delete();
      e_c = '0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_bo = 1'b0;
      chk_en = 1'b1;
    end else begin
      if (exp_q.size() == 0 && s) begin
        d = cur_a - cur_b;
        for (int k = 0; k < CC; k++) exp_q.push_back(d[k*W +: W]);
        op_bo = (cur_a < cur_b);
      end
      if (exp_q.size() > 0) begin
        e_c     = exp_q.pop_front();
        e_valid = 1'b1;
        e_busy  = (exp_q.size() > 0);
        e_done  = (exp_q.size() == 0);
        if (e_done) e_bo = op_bo;
      end else begin
        e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  // ---------------- compare process + capture ----------------
  logic [W-1:0] got_c[$];
  int           done_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("c_valid", 32'(bus.c_valid), 32'(e_valid));
      chk("c",       32'(bus.c),       32'(e_c));
      chk("busy",    32'(bus.busy),    32'(e_busy));
      chk("done",    32'(bus.done),    32'(e_done));
`ifdef SUB_BORROW_OUT_EN
      chk("borrow_out", 32'(bus.borrow_out), 32'(e_bo));
`endif
      if (bus.c_valid === 1'b1) got_c.push_back(bus.c);
      if (bus.done === 1'b1) done_q.push_back(cyc);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    #1;
    rst = r; bus.start = s; bus.a = av; bus.b = bv;
    step_cyc = cyc;
    model_step(r, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));
  endtask

  // abort_at < 0 runs to completion; otherwise reset (with start also high)
  // is applied in place of chunk abort_at.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input bit hold, input int abort_at);
    logic s;
    cur_a = av; cur_b = bv;
    for (int k = 0; k < CC; k++) begin
      if (k == abort_at) begin
        step(1'b1, 1'b1, av[k*W +: W], bv[k*W +: W]);
        return;
      end
      s = (k == 0) ? 1'b1 : (hold ? 1'b1 : 1'($urandom_range(0, 1)));
      step(1'b0, s, av[k*W +: W], bv[k*W +: W]);
      if (k == 0) op_t0 = step_cyc;
    end
  endtask

  task automatic clear_caps();
    got_c.delete();
    done_q.delete();
  endtask

  task automatic chk_chunks(input string nm, input int first, input logic [W-1:0] c0,
                            input logic [W-1:0] c1, input logic [W-1:0] rest);
    for (int k = 0; k < CC; k++) begin
      if (first + k < got_c.size())
        chk(nm, 32'(got_c[first + k]), 32'((k == 0) ? c0 : (k == 1) ? c1 : rest));
      else
        chk({nm, "_missing"}, 32'(first + k), 32'(got_c.size()));
    end
  endtask

  task automatic chk_done1(input string nm);
    chk({nm, "_done_count"}, 32'(done_q.size()), 32'd1);
    if (done_q.size() == 1) chk({nm, "_done_cycle"}, 32'(done_q[0] - op_t0), 32'(CC));
  endtask

  logic [N-1:0] ra, rb;
  int           t1;

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, '0, '0);
    idle(2);

    // 5 - 3
    clear_caps();
    run_op(N'(5), N'(3), 1'b0, -1);
    idle(2);
    chk_chunks("lit_5m3", 0, 4'h2, 4'h0, 4'h0);
    chk_done1("lit_5m3");
`ifdef SUB_BORROW_OUT_EN
    chk("lit_5m3_bo", 32'(bus.borrow_out), 32'd0);
`endif

    // 0 - 1
    clear_caps();
    run_op(N'(0), N'(1), 1'b0, -1);
    idle(2);
    chk_chunks("lit_0m1", 0, 4'hF, 4'hF, 4'hF);
    chk_done1("lit_0m1");
`ifdef SUB_BORROW_OUT_EN
    chk("lit_0m1_bo", 32'(bus.borrow_out), 32'd1);
`endif

    // all ones - all ones
    clear_caps();
    run_op({N{1'b1}}, {N{1'b1}}, 1'b0, -1);
    idle(1);
    chk_chunks("lit_ones", 0, 4'h0, 4'h0, 4'h0);
`ifdef SUB_BORROW_OUT_EN
    chk("lit_ones_bo", 32'(bus.borrow_out), 32'd0);
`endif

    // 0x10 - 0x01: borrow crosses from chunk 0 into chunk 1
    clear_caps();
    run_op(N'(16), N'(1), 1'b0, -1);
    idle(1);
    chk_chunks("lit_10m01", 0, 4'hF, 4'h0, 4'h0);

    // reset at cycle 10 of an operation that borrows in every chunk
    clear_caps();
    run_op(N'(0), N'(1), 1'b0, 10);
    @(negedge clk);
    #1;
    chk("abort_c_valid", 32'(bus.c_valid), 32'd0);
    chk("abort_busy",    32'(bus.busy),    32'd0);
    chk("abort_c",       32'(bus.c),       32'd0);
    rst = 1'b0; bus.start = 1'b0;
    model_step(1'b0, 1'b0);
    idle(3);
    chk("abort_no_done", 32'(done_q.size()), 32'd0);
    clear_caps();
    run_op(N'(7), N'(2), 1'b0, -1);
    idle(1);
    chk_chunks("lit_7m2", 0, 4'h5, 4'h0, 4'h0);

    // start held high through two back-to-back operations
    clear_caps();
    run_op(N'(5), N'(3), 1'b1, -1);
    t1 = op_t0;
    run_op(N'(0), N'(1), 1'b1, -1);
    idle(2);
    chk("b2b_done_count", 32'(done_q.size()), 32'd2);
    if (done_q.size() == 2) begin
      chk("b2b_done0", 32'(done_q[0] - t1), 32'd32);
      chk("b2b_done1", 32'(done_q[1] - t1), 32'd64);
    end
    chk_chunks("b2b_op1", 0,  4'h2, 4'h0, 4'h0);
    chk_chunks("b2b_op2", CC, 4'hF, 4'hF, 4'hF);
`ifdef SUB_BORROW_OUT_EN
    chk("b2b_bo", 32'(bus.borrow_out), 32'd1);
`endif

    // randomized operations, checked cycle by cycle against the model
    for (int n = 0; n < 40; n++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 5) == 0) rb = ra;
      if ($urandom_range(0, 5) == 0) rb[N-1 -: 32] = ra[N-1 -: 32];
      run_op(ra, rb, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, CC - 1)) : -1);
      idle(int'($urandom_range(0, 3)));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
